// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM bank controller:
// default bus widths, active-low pin levels and FSM state encoding.
package sram_ctrl_pkg;

    // Default geometry of one 1M x 32 bank
    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 32;

    // Active-low pin levels
    localparam logic SRAM_ASSERT   = 1'b0;
    localparam logic SRAM_DEASSERT = 1'b1;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ACC   = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bus between a CPU/MMU master and the SRAM controller.
//   req_valid/req_ready  : valid/ready handshake, one request outstanding
//   req_we/addr/wdata/be : request payload, latched on acceptance
//   resp_valid           : one-cycle completion pulse
//   resp_rdata           : last read data, held until the next read completes
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W
) ();

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_ctrl.sv
// Bus-master controller for one asynchronous SRAM bank. Turns a single
// outstanding valid/ready request into timed ce/oe/we pin sequences.
// Partial-word writes are done as read-modify-write since the chip has
// no byte lanes.
// Ports:
//   clk        : memory clock, all logic on posedge
//   rst        : synchronous active-high reset
//   bus        : request/response bus (slave side)
//   sram_addr  : SRAM word address
//   sram_data  : SRAM data, driven only in write states
//   sram_ce/oe/we : active-low chip, output and write enables
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH  = SRAM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_ctrl_if.slave            bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce,
    output logic                  sram_oe,
    output logic                  sram_we
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [BE_WIDTH-1:0]  BE_FULL  = {BE_WIDTH{1'b1}};

    logic [2:0]            state;
    logic [2:0]            state_n;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic                  accept;
    logic                  phase_end;
    logic                  rmw_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic                  drive;
    logic                  ce_d;
    logic                  oe_d;
    logic                  we_d;
    logic                  drive_d;

    // Replace the read-back bytes selected by be with the write data bytes
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = rdata;
        for (int i = 0; i < int'(BE_WIDTH); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign phase_end = (cnt == CNT_LAST);
    assign sram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // Next-state logic and pin decode of the upcoming state
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (!bus.req_we) begin
                        state_n = ST_RD_ACC;
                    end else if (bus.req_be == '0) begin
                        state_n = ST_DONE;
                    end else if (bus.req_be == BE_FULL) begin
                        state_n = ST_WR_SETUP;
                    end else begin
                        state_n = ST_RD_ACC;
                    end
                end
            end
            ST_RD_ACC: begin
                if (phase_end) begin
                    cnt_n   = '0;
                    state_n = rmw_q ? ST_WR_SETUP : ST_DONE;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            ST_WR_SETUP: begin
                cnt_n   = '0;
                state_n = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (phase_end) begin
                    state_n = ST_WR_HOLD;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            ST_WR_HOLD: state_n = ST_DONE;
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase

        ce_d    = (state_n inside {ST_RD_ACC, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD})
                  ? SRAM_ASSERT : SRAM_DEASSERT;
        oe_d    = (state_n == ST_RD_ACC)   ? SRAM_ASSERT : SRAM_DEASSERT;
        we_d    = (state_n == ST_WR_PULSE) ? SRAM_ASSERT : SRAM_DEASSERT;
        drive_d = (state_n inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    end

    // State, pins, latched request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rmw_q          <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            drive          <= 1'b0;
            sram_addr      <= '0;
            sram_ce        <= SRAM_DEASSERT;
            sram_oe        <= SRAM_DEASSERT;
            sram_we        <= SRAM_DEASSERT;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            drive          <= drive_d;
            sram_ce        <= ce_d;
            sram_oe        <= oe_d;
            sram_we        <= we_d;
            bus.req_ready  <= (state_n == ST_IDLE);
            bus.resp_valid <= (state_n == ST_DONE);

            if (accept) begin
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
                rmw_q   <= bus.req_we && (bus.req_be != '0) && (bus.req_be != BE_FULL);
                // A zero-byte write must leave the pins untouched
                if (!(bus.req_we && (bus.req_be == '0))) begin
                    sram_addr <= bus.req_addr;
                end
            end

            // Last read edge: capture for the response, or merge for RMW
            if ((state == ST_RD_ACC) && phase_end) begin
                if (rmw_q) begin
                    wdata_q <= merge_bytes(wdata_q, sram_data, be_q);
                end else begin
                    bus.resp_rdata <= sram_data;
                end
            end
        end
    end

endmodule
